// File: rtl/tile_pkg.sv
// Shared encodings for the CGRA processing tile: opcodes, ALU ops, FSM states,
// direction numbering and instruction field positions derived from RA/DW/IMM_W.
package tile_pkg;

    typedef enum logic [2:0] {
        OP_ALU  = 3'd0,
        OP_LDI  = 3'd1,
        OP_SEND = 3'd2,
        OP_RECV = 3'd3,
        OP_OUT  = 3'd4,
        OP_BNZ  = 3'd5,
        OP_NOP  = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_MUL = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } aluop_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALT
    } state_t;

    localparam int DIR_N  = 0;
    localparam int DIR_NE = 1;
    localparam int DIR_E  = 2;
    localparam int DIR_SE = 3;
    localparam int DIR_S  = 4;
    localparam int DIR_SW = 5;
    localparam int DIR_W  = 6;
    localparam int DIR_NW = 7;

    localparam int OP_W    = 3;
    localparam int ALUOP_W = 3;

    // Field layout, LSB first: op, dst, src1, src2, dir, aluop, imm.
    function automatic int f_dst_lsb();
        return OP_W;
    endfunction

    function automatic int f_src1_lsb(input int ra);
        return OP_W + ra;
    endfunction

    function automatic int f_src2_lsb(input int ra);
        return OP_W + 2 * ra;
    endfunction

    function automatic int f_dir_lsb(input int ra);
        return OP_W + 3 * ra;
    endfunction

    function automatic int f_aluop_lsb(input int ra, input int dw);
        return OP_W + 3 * ra + dw;
    endfunction

    function automatic int f_imm_lsb(input int ra, input int dw);
        return OP_W + 3 * ra + dw + ALUOP_W;
    endfunction

    function automatic int f_instr_w(input int ra, input int dw, input int imm_w);
        return f_imm_lsb(ra, dw) + imm_w;
    endfunction

endpackage

// File: rtl/tile_alu.sv
// Combinational tile ALU; results wrap modulo 2^DATA_W, shifts of DATA_W or
// more produce zero.
module tile_alu
    import tile_pkg::*;
#(
    parameter int DATA_W = 48
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  aluop_t            i_op,
    output logic [DATA_W-1:0] o_y
);

    localparam int SW = $clog2(DATA_W);

    logic [SW-1:0] w_sh;
    assign w_sh = i_b[SW-1:0];

    always_comb begin
        o_y = '0;
        case (i_op)
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_XOR: o_y = i_a ^ i_b;
            ALU_MUL: o_y = i_a * i_b;
            ALU_SHL: o_y = (int'(w_sh) >= DATA_W) ? '0 : (i_a << w_sh);
            ALU_SHR: o_y = (int'(w_sh) >= DATA_W) ? '0 : (i_a >> w_sh);
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/tile_pe.sv
// CGRA processing tile: instruction memory, register file, ALU and stalling
// valid/ready links to NUM_DIRS neighbours; one instruction per cycle.
module tile_pe
    import tile_pkg::*;
#(
    parameter  int TILE_ID    = 0,
    parameter  int DATA_W     = 48,
    parameter  int NUM_REGS   = 16,
    parameter  int IMEM_DEPTH = 64,
    parameter  int NUM_DIRS   = 8,
    parameter  int IMM_W      = 16,
    localparam int RA         = $clog2(NUM_REGS),
    localparam int IA         = $clog2(IMEM_DEPTH),
    localparam int DW         = $clog2(NUM_DIRS),
    localparam int INSTR_W    = f_instr_w(RA, DW, IMM_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       program_mode,
    input  logic                       prog_we,
    input  logic [IA-1:0]              prog_addr,
    input  logic [INSTR_W-1:0]         prog_wdata,
    output logic [NUM_DIRS*DATA_W-1:0] send_data,
    output logic [NUM_DIRS-1:0]        send_valid,
    input  logic [NUM_DIRS-1:0]        send_ready,
    input  logic [NUM_DIRS*DATA_W-1:0] recv_data,
    input  logic [NUM_DIRS-1:0]        recv_valid,
    output logic [NUM_DIRS-1:0]        recv_ready,
    output logic [DATA_W-1:0]          tile_output,
    output logic                       tile_output_valid,
    output logic                       halted
);

    localparam int DST_LSB   = f_dst_lsb();
    localparam int SRC1_LSB  = f_src1_lsb(RA);
    localparam int SRC2_LSB  = f_src2_lsb(RA);
    localparam int DIR_LSB   = f_dir_lsb(RA);
    localparam int ALUOP_LSB = f_aluop_lsb(RA, DW);
    localparam int IMM_LSB   = f_imm_lsb(RA, DW);

    state_t              r_state;
    logic [IA-1:0]       r_ip;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [INSTR_W-1:0]  r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0]   r_out;
    logic                r_out_valid;

    logic [INSTR_W-1:0]  w_instr;
    opcode_t             w_op;
    logic [RA-1:0]       w_dst, w_src1, w_src2;
    logic [DW-1:0]       w_dir;
    aluop_t              w_aluop;
    logic [IMM_W-1:0]    w_imm;
    logic [DATA_W-1:0]   w_rs1, w_rs2, w_alu_y, w_imm_sx, w_recv_word;
    logic [IA-1:0]       w_ip_next;
    logic                w_run, w_dir_ok, w_send_en, w_recv_en, w_send_done, w_recv_done;

    assign w_instr  = r_imem[r_ip];
    assign w_op     = opcode_t'(w_instr[OP_W-1:0]);
    assign w_dst    = w_instr[DST_LSB +: RA];
    assign w_src1   = w_instr[SRC1_LSB +: RA];
    assign w_src2   = w_instr[SRC2_LSB +: RA];
    assign w_dir    = w_instr[DIR_LSB +: DW];
    assign w_aluop  = aluop_t'(w_instr[ALUOP_LSB +: ALUOP_W]);
    assign w_imm    = w_instr[IMM_LSB +: IMM_W];
    assign w_imm_sx = DATA_W'($signed(w_imm));

    assign w_rs1 = r_regs[w_src1];
    assign w_rs2 = r_regs[w_src2];

    assign w_ip_next = (r_ip == IA'(IMEM_DEPTH - 1)) ? '0 : r_ip + IA'(1);

    // Link strobes derive only from registered state; program_mode gates them so a
    // stalled handshake is withdrawn in the same cycle the tile is taken over.
    assign w_run       = (r_state == ST_RUN) && !program_mode;
    assign w_dir_ok    = (int'(w_dir) < NUM_DIRS);
    assign w_send_en   = w_run && (w_op == OP_SEND) && w_dir_ok;
    assign w_recv_en   = w_run && (w_op == OP_RECV) && w_dir_ok;
    assign w_send_done = w_send_en && send_ready[w_dir];
    assign w_recv_done = w_recv_en && recv_valid[w_dir];
    assign w_recv_word = recv_data[int'(w_dir)*DATA_W +: DATA_W];

    always_comb begin
        send_valid = '0;
        send_data  = '0;
        recv_ready = '0;
        if (w_send_en) begin
            send_valid[w_dir] = 1'b1;
            send_data[int'(w_dir)*DATA_W +: DATA_W] = w_rs1;
        end
        if (w_recv_en) begin
            recv_ready[w_dir] = 1'b1;
        end
    end

    tile_alu #(.DATA_W(DATA_W)) u_alu (
        .i_a  (w_rs1),
        .i_b  (w_rs2),
        .i_op (w_aluop),
        .o_y  (w_alu_y)
    );

    // Imem is not reset; a write coinciding with the mode exit still lands.
    always_ff @(posedge clk) begin
        if (prog_we && (program_mode || r_state == ST_LOAD)) begin
            r_imem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_ip        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (program_mode) begin
                r_state <= ST_LOAD;
                r_ip    <= '0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        r_state <= ST_RUN;
                        r_ip    <= '0;
                    end
                    ST_HALT: r_state <= ST_HALT;
                    default: begin
                        case (w_op)
                            OP_ALU: begin
                                r_regs[w_dst] <= w_alu_y;
                                r_ip          <= w_ip_next;
                            end
                            OP_LDI: begin
                                r_regs[w_dst] <= w_imm_sx;
                                r_ip          <= w_ip_next;
                            end
                            OP_SEND: begin
                                if (!w_dir_ok || w_send_done) r_ip <= w_ip_next;
                            end
                            OP_RECV: begin
                                if (!w_dir_ok) begin
                                    r_ip <= w_ip_next;
                                end else if (w_recv_done) begin
                                    r_regs[w_dst] <= w_recv_word;
                                    r_ip          <= w_ip_next;
                                end
                            end
                            OP_OUT: begin
                                r_out       <= w_rs1;
                                r_out_valid <= 1'b1;
                                r_ip        <= w_ip_next;
                            end
                            OP_BNZ:  r_ip <= (w_rs1 != '0) ? w_imm[IA-1:0] : w_ip_next;
                            OP_HALT: r_state <= ST_HALT;
                            default: r_ip <= w_ip_next;
                        endcase
                    end
                endcase
            end
        end
    end

    assign tile_output       = r_out;
    assign tile_output_valid = r_out_valid;
    assign halted            = (r_state == ST_HALT);

endmodule

// File: tb/tb_tile_pe.sv
// Bench for tile_pe: directed link/branch/wrap scenarios plus random ALU
// programs checked against an instruction-level reference interpreter.
module tb_tile_pe;

    localparam int AW = 48, AD = 8, A_IW = 37;
    localparam int BW = 32, BD = 4, B_IW = 36;

    localparam int OP_ALU = 0, OP_LDI = 1, OP_SEND = 2, OP_RECV = 3;
    localparam int OP_OUT = 4, OP_BNZ = 5, OP_NOP = 6, OP_HALT = 7;
    localparam int A_ADD = 0, A_SUB = 1, A_MUL = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              a_pm, a_we;
    logic [5:0]        a_addr;
    logic [A_IW-1:0]   a_wdata;
    logic [AD*AW-1:0]  a_sdata, a_rdata;
    logic [AD-1:0]     a_sv, a_sr, a_rv, a_rr;
    logic [AW-1:0]     a_out;
    logic              a_ov, a_halt;

    logic              b_pm, b_we;
    logic [5:0]        b_addr;
    logic [B_IW-1:0]   b_wdata;
    logic [BD*BW-1:0]  b_sdata, b_rdata;
    logic [BD-1:0]     b_sv, b_sr, b_rv, b_rr;
    logic [BW-1:0]     b_out;
    logic              b_ov, b_halt;

    tile_pe #(.TILE_ID(0)) u_a (
        .clk(clk), .rst(rst), .program_mode(a_pm), .prog_we(a_we),
        .prog_addr(a_addr), .prog_wdata(a_wdata),
        .send_data(a_sdata), .send_valid(a_sv), .send_ready(a_sr),
        .recv_data(a_rdata), .recv_valid(a_rv), .recv_ready(a_rr),
        .tile_output(a_out), .tile_output_valid(a_ov), .halted(a_halt)
    );

    tile_pe #(.TILE_ID(1), .DATA_W(BW), .NUM_DIRS(BD)) u_b (
        .clk(clk), .rst(rst), .program_mode(b_pm), .prog_we(b_we),
        .prog_addr(b_addr), .prog_wdata(b_wdata),
        .send_data(b_sdata), .send_valid(b_sv), .send_ready(b_sr),
        .recv_data(b_rdata), .recv_valid(b_rv), .recv_ready(b_rr),
        .tile_output(b_out), .tile_output_valid(b_ov), .halted(b_halt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [63:0] a_outs[$], b_outs[$], exp_q[$];
    always @(negedge clk) begin
        if (a_ov) a_outs.push_back(64'(a_out));
        if (b_ov) b_outs.push_back(64'(b_out));
    end

    typedef struct { int addr; logic [63:0] w; } pw_t;
    pw_t prog_q[$];
    int  next_addr = 0;
    int  cur_dw = 3;

    function automatic logic [63:0] enc(input int dw, input int op, input int dst, input int s1,
                                        input int s2, input int dir, input int aop, input int imm);
        logic [63:0] w;
        w = 64'(op & 7);
        w |= 64'(dst & 15) << 3;
        w |= 64'(s1 & 15) << 7;
        w |= 64'(s2 & 15) << 11;
        w |= 64'(dir & ((1 << dw) - 1)) << 15;
        w |= 64'(aop & 7) << (15 + dw);
        w |= 64'(imm & 32'hFFFF) << (18 + dw);
        return w;
    endfunction

    task automatic emit(input int op, input int dst, input int s1, input int s2,
                        input int dir, input int aop, input int imm);
        pw_t e;
        e.addr = next_addr;
        e.w    = enc(cur_dw, op, dst, s1, s2, dir, aop, imm);
        prog_q.push_back(e);
        next_addr++;
    endtask

    task automatic drv(input int sel, input logic pm, input logic we, input int addr, input logic [63:0] w);
        if (sel == 0) begin
            a_pm = pm; a_we = we; a_addr = 6'(addr); a_wdata = w[A_IW-1:0];
        end else begin
            b_pm = pm; b_we = we; b_addr = 6'(addr); b_wdata = w[B_IW-1:0];
        end
    endtask

    // Writes the queued program; the final word goes in as program_mode drops.
    task automatic load(input int sel);
        a_outs.delete();
        b_outs.delete();
        drv(sel, 1'b1, 1'b0, 0, '0);
        @(negedge clk);
        foreach (prog_q[i]) begin
            drv(sel, (i != prog_q.size() - 1), 1'b1, prog_q[i].addr, prog_q[i].w);
            @(negedge clk);
        end
        drv(sel, 1'b0, 1'b0, 0, '0);
        prog_q.delete();
        next_addr = 0;
    endtask

    task automatic wait_halt(input int sel, input string tag);
        int n = 0;
        while (((sel == 0) ? a_halt : b_halt) !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".halted"}, 64'((sel == 0) ? a_halt : b_halt), 64'd1);
    endtask

    task automatic check_outs(input int sel, input string tag);
        logic [63:0] got[$];
        got = (sel == 0) ? a_outs : b_outs;
        check({tag, ".count"}, 64'(got.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            check($sformatf("%s.out%0d", tag, i),
                  (i < got.size()) ? got[i] : 64'hDEAD_DEAD_DEAD_DEAD, exp_q[i]);
        end
        exp_q.delete();
    endtask

    task automatic wait_bit(input logic [7:0] vec_sel, input int bitn);
        int n = 0;
        while (((vec_sel == 0) ? a_sv[bitn] : a_rr[bitn]) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Instruction-level reference: wrap-around arithmetic expressed numerically.
    function automatic logic [AW-1:0] model_alu(input int aop, input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [2*AW-1:0] pw, prod;
        int n;
        n  = int'(b % 64);
        pw = 1;
        repeat (n) pw = pw * 2;
        prod = a * b;
        case (aop)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return prod[AW-1:0];
            6: return (n >= AW) ? '0 : AW'(a * pw);
            7: return (n >= AW) ? '0 : AW'(a / pw);
            default: return '0;
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] m [16];
        logic [15:0]   v;
        int            aop, d, s1, s2;

        rst = 1'b1;
        a_sr = '0; a_rv = '0; a_rdata = '0;
        b_sr = '0; b_rv = '0; b_rdata = '0;
        drv(0, 1'b0, 1'b0, 0, '0);
        drv(1, 1'b0, 1'b0, 0, '0);
        repeat (2) @(negedge clk);

        // Fill both memories with NOPs while held in reset.
        for (int s = 0; s < 2; s++) begin
            cur_dw = (s == 0) ? 3 : 2;
            repeat (64) emit(OP_NOP, 0, 0, 0, 0, 0, 0);
            next_addr = 63;
            emit(OP_NOP, 0, 0, 0, 0, 0, 0);
            load(s);
        end
        @(negedge clk);
        check("rst.halted",     64'(a_halt), 64'd0);
        check("rst.send_valid", 64'(a_sv),   64'd0);
        check("rst.recv_ready", 64'(a_rr),   64'd0);
        check("rst.out",        64'(a_out),  64'd0);
        check("rst.out_valid",  64'(a_ov),   64'd0);
        check("rst.b_halted",   64'(b_halt), 64'd0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("run.halted",     64'(a_halt), 64'd0);
        check("run.out_pulses", 64'(a_outs.size()), 64'd0);

        cur_dw = 3;
        emit(OP_OUT, 0, 9, 0, 0, 0, 0);
        emit(OP_HALT, 0, 0, 0, 0, 0, 0);
        load(0);
        wait_halt(0, "regrst");
        exp_q.push_back(64'd0);
        check_outs(0, "regrst");

        emit(OP_LDI, 1, 0, 0, 0, 0, 5);
        emit(OP_LDI, 2, 0, 0, 0, 0, -3);
        emit(OP_ALU, 3, 1, 2, 0, A_ADD, 0);
        emit(OP_OUT, 0, 3, 0, 0, 0, 0);
        emit(OP_HALT, 0, 0, 0, 0, 0, 0);
        load(0);
        wait_halt(0, "add");
        exp_q.push_back(64'd2);
        check_outs(0, "add");
        check("add.tile_output", 64'(a_out), 64'd2);
        check("add.valid_low",   64'(a_ov),  64'd0);

        emit(OP_LDI, 1, 0, 0, 0, 0, 7);
        emit(OP_SEND, 0, 1, 0, 2, 0, 0);
        emit(OP_OUT, 0, 1, 0, 0, 0, 0);
        emit(OP_HALT, 0, 0, 0, 0, 0, 0);
        load(0);
        wait_bit(0, 2);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("send.valid%0d", k), 64'(a_sv), 64'h04);
            check($sformatf("send.data%0d", k), 64'(a_sdata[2*AW +: AW]), 64'd7);
            if (k == 3) a_sr[2] = 1'b1;
            @(negedge clk);
        end
        a_sr = '0;
        check("send.valid_drop", 64'(a_sv), 64'd0);
        wait_halt(0, "send");
        exp_q.push_back(64'd7);
        check_outs(0, "send");

        emit(OP_RECV, 4, 0, 0, 5, 0, 0);
        emit(OP_OUT, 0, 4, 0, 0, 0, 0);
        emit(OP_HALT, 0, 0, 0, 0, 0, 0);
        load(0);
        wait_bit(1, 5);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("recv.ready%0d", k), 64'(a_rr), 64'h20);
            check($sformatf("recv.sv%0d", k), 64'(a_sv), 64'd0);
            if (k == 2) begin
                a_rv = '1;
                for (int dd = 0; dd < AD; dd++) a_rdata[dd*AW +: AW] = (dd == 5) ? 48'h123 : 48'hB00 + 48'(dd);
            end
            @(negedge clk);
        end
        a_rv = '0;
        check("recv.ready_drop", 64'(a_rr), 64'd0);
        wait_halt(0, "recv");
        exp_q.push_back(64'h123);
        check_outs(0, "recv");

        emit(OP_LDI, 1, 0, 0, 0, 0, 3);
        emit(OP_LDI, 2, 0, 0, 0, 0, 1);
        emit(OP_OUT, 0, 1, 0, 0, 0, 0);
        emit(OP_ALU, 1, 1, 2, 0, A_SUB, 0);
        emit(OP_BNZ, 0, 1, 0, 0, 0, 2);
        emit(OP_OUT, 0, 1, 0, 0, 0, 0);
        emit(OP_HALT, 0, 0, 0, 0, 0, 0);
        load(0);
        wait_halt(0, "loop");
        for (int k = 3; k >= 0; k--) exp_q.push_back(64'(k));
        check_outs(0, "loop");

        emit(OP_LDI, 1, 0, 0, 0, 0, 7);
        emit(OP_SEND, 0, 1, 0, 2, 0, 0);
        emit(OP_HALT, 0, 0, 0, 0, 0, 0);
        load(0);
        wait_bit(0, 2);
        @(negedge clk);
        check("abort.stalled", 64'(a_sv), 64'h04);
        drv(0, 1'b1, 1'b0, 0, '0);
        #1;
        check("abort.same_cycle", 64'(a_sv), 64'd0);
        @(negedge clk);
        check("abort.next_cycle", 64'(a_sv), 64'd0);
        check("abort.not_halted", 64'(a_halt), 64'd0);
        emit(OP_OUT, 0, 1, 0, 0, 0, 0);
        emit(OP_HALT, 0, 0, 0, 0, 0, 0);
        load(0);
        wait_halt(0, "abort");
        exp_q.push_back(64'd7);
        check_outs(0, "abort");

        cur_dw = 2;
        emit(OP_OUT, 0, 1, 0, 0, 0, 0);
        emit(OP_BNZ, 0, 1, 0, 0, 0, 10);
        emit(OP_LDI, 1, 0, 0, 0, 0, 1);
        emit(OP_BNZ, 0, 1, 0, 0, 0, 63);
        next_addr = 10;
        emit(OP_LDI, 2, 0, 0, 0, 0, -1);
        emit(OP_LDI, 3, 0, 0, 0, 0, 2);
        emit(OP_ALU, 4, 2, 3, 0, A_MUL, 0);
        emit(OP_OUT, 0, 4, 0, 0, 0, 0);
        emit(OP_HALT, 0, 0, 0, 0, 0, 0);
        next_addr = 63;
        emit(OP_NOP, 0, 0, 0, 0, 0, 0);
        load(1);
        wait_halt(1, "wrap");
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        exp_q.push_back(64'hFFFF_FFFE);
        check_outs(1, "wrap");

        cur_dw = 3;
        for (int it = 0; it < 8; it++) begin
            for (int r = 0; r < 16; r++) begin
                v = 16'($urandom_range(0, 65535));
                if ($urandom_range(0, 7) == 0) v = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'hFFFF;
                emit(OP_LDI, r, 0, 0, 0, 0, int'(v));
                m[r] = {{(AW-16){v[15]}}, v};
            end
            for (int j = 0; j < 12; j++) begin
                aop = int'($urandom_range(0, 7));
                d   = int'($urandom_range(0, 15));
                s1  = int'($urandom_range(0, 15));
                s2  = int'($urandom_range(0, 15));
                emit(OP_ALU, d, s1, s2, 0, aop, 0);
                m[d] = model_alu(aop, m[s1], m[s2]);
            end
            for (int r = 0; r < 16; r++) begin
                emit(OP_OUT, 0, r, 0, 0, 0, 0);
                exp_q.push_back(64'(m[r]));
            end
            emit(OP_HALT, 0, 0, 0, 0, 0, 0);
            load(0);
            wait_halt(0, $sformatf("rand%0d", it));
            check_outs(0, $sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tile_pe.md
# tile_pe

Parametrised successor CGRA processing tile: word-wide instruction load port, generic register file, an internal ALU, and per-direction valid/ready links to `NUM_DIRS` neighbours. Instructions execute one per cycle; sends and receives stall the tile until the partner handshakes. Sits in the tile array; neighbour buses connect to the array fabric, and `tile_output` feeds the array result collector.

## Interface
- `TILE_ID`, 0, tile index, informational only.
- `DATA_W`, 48, register and link width.
- `NUM_REGS`, 16, register count; `RA = $clog2(NUM_REGS)`.
- `IMEM_DEPTH`, 64, instruction words; `IA = $clog2(IMEM_DEPTH)`.
- `NUM_DIRS`, 8, neighbour links (N, NE, E, SE, S, SW, W, NW = 0..7); `DW = $clog2(NUM_DIRS)`.
- `IMM_W`, 16, immediate width; `INSTR_W = 3 + 3*RA + DW + 3 + IMM_W`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `program_mode`  in  1  high: load mode, no execution.
- `prog_we`  in  1  instruction write strobe, honoured only in load mode.
- `prog_addr`  in  IA  instruction write address.
- `prog_wdata`  in  INSTR_W  instruction word.
- `send_data`  out  NUM_DIRS*DATA_W  slice d = data toward direction d.
- `send_valid`  out  NUM_DIRS  per-direction valid.
- `send_ready`  in  NUM_DIRS  per-direction ready.
- `recv_data`  in  NUM_DIRS*DATA_W  slice d = data from direction d.
- `recv_valid`  in  NUM_DIRS  per-direction valid.
- `recv_ready`  out  NUM_DIRS  per-direction ready.
- `tile_output`  out  DATA_W  last OUT value.
- `tile_output_valid`  out  1  one-cycle pulse per OUT.
- `halted`  out  1  high in HALT state.

## Operation
- Field layout (LSB first): op[2:0], dst, src1, src2 (RA each), dir (DW), aluop (3), imm (IMM_W).
- Opcodes: 000 ALU, 001 LDI, 010 SEND, 011 RECV, 100 OUT, 101 BNZ, 110 NOP, 111 HALT.
- ALU: `dst <= f(src1, src2)`; aluop 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL (low DATA_W bits), 6 SHL, 7 SHR logical; shift amount is src2 low `$clog2(DATA_W)` bits, and amounts ≥ DATA_W give 0. Results wrap modulo 2^DATA_W.
- LDI: `dst <= sign-extend(imm)`.
- SEND: `send_valid[dir]` and `send_data[dir]` = `registers[src1]`; ip holds until `send_ready[dir]`.
- RECV: `recv_ready[dir]` asserted; ip holds until `recv_valid[dir]`, then `dst <= recv_data[dir]`.
- OUT: `tile_output <= registers[src1]`, pulse valid.
- BNZ: if `registers[src1] != 0`, `ip <= imm[IA-1:0]`, else `ip+1`.
- HALT: enter HALT; stays until `rst` or `program_mode`.
- ip increments modulo IMEM_DEPTH (wraps IMEM_DEPTH-1 -> 0).
- `dir >= NUM_DIRS` on SEND/RECV: treated as NOP.
- States: LOAD (`program_mode`=1), RUN, HALT. LOAD->RUN on `program_mode` low with ip=0. Any state->LOAD when `program_mode` rises. RUN->HALT on HALT op.

## Timing
- Reset: state RUN, ip 0, registers 0, all `send_valid`/`recv_ready` 0, `tile_output` 0, `tile_output_valid` 0, `halted` 0. Instruction memory is not cleared by reset.
- `send_valid`, `send_data`, and `recv_ready` are combinational from registered state (state, ip, registers, imem); they never depend on `send_ready`/`recv_valid`.
- Transfer occurs on a clock edge with valid&&ready; a zero-wait handshake completes the instruction in 1 cycle.
- Non-stalling instructions take 1 cycle; register write is visible to the next instruction.
- `program_mode` rising mid-stall drops the handshake the same cycle (valid/ready go 0) without a transfer; registers are retained.
- `prog_we` with a simultaneous mode exit: the write still lands.

## Structure
- `tile_pkg`: opcode and aluop constants, direction encoding, field offset/width functions of RA/DW/IMM_W.
- Sub-module `tile_alu` (combinational, DATA_W parametrised); sequencing, register file, and link handling stay in `tile_pe`.

## Test plan
- Load LDI r1=5; LDI r2=-3; ALU ADD r3=r1+r2; OUT r3; HALT -> `tile_output`=2 with a single valid pulse, then `halted`=1.
- SEND r1 (=7) dir 2 with `send_ready[2]` low for 3 cycles -> `send_valid[2]` held 4 cycles, data 7, ip advances exactly once.
- RECV dir 5 into r4, `recv_valid[5]` arrives after 2 cycles carrying 0x123 -> `recv_ready[5]` is the only ready high, r4=0x123, other ready bits 0.
- Loop: r1=3; body SUB r1=r1-1; BNZ r1 -> body -> body runs 3 times, then falls through.
- `program_mode` raised during a stalled SEND -> `send_valid`=0 next cycle; after reload, execution restarts at ip 0.
- NUM_DIRS=4, DATA_W=32, wrap test: ip at 63 executing NOP -> next fetch at ip 0; MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
